// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, types and helpers for the LCD character sequencer
// Purpose: HD44780 command codes, ASCII control codes, FSM state/phase enums,
//          the op record stored in the op list, and small op-building helpers.
// Ports:   none (package).
package lcd_pkg;

  localparam logic [7:0] FUNC_SET_8BIT = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] DDRAM_L0      = 8'h80;
  localparam logic [7:0] DDRAM_L1      = 8'hC0;

  localparam logic [7:0] BS          = 8'h08;
  localparam logic [7:0] LF          = 8'h0A;
  localparam logic [7:0] SPACE       = 8'h20;
  localparam logic [7:0] PRINT_FIRST = 8'h20;
  localparam logic [7:0] PRINT_LAST  = 8'h7E;
  localparam logic [3:0] LAST_COL    = 4'd15;

  typedef enum logic [1:0] {
    ST_POWERUP,
    ST_INIT,
    ST_IDLE,
    ST_EXEC
  } lcd_state_e;

  // PH_START is the wait for the tick that opens SETUP; PH_CLR is the
  // extra settle time that only follows a clear-display write.
  typedef enum logic [2:0] {
    PH_START,
    PH_SETUP,
    PH_E_HI,
    PH_E_LO,
    PH_CLR
  } lcd_phase_e;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       long_wait;
  } lcd_op_t;

  function automatic lcd_op_t cmd_op(input logic [7:0] code);
    lcd_op_t op;
    op.rs        = 1'b0;
    op.data      = code;
    op.long_wait = (code == CLEAR);
    return op;
  endfunction

  function automatic lcd_op_t data_op(input logic [7:0] chr);
    lcd_op_t op;
    op.rs        = 1'b1;
    op.data      = chr;
    op.long_wait = 1'b0;
    return op;
  endfunction

  // Set-DDRAM-address command: line 1 starts at address 0x40.
  function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
    return {1'b1, row, 2'b00, col};
  endfunction

  function automatic lcd_op_t init_op(input logic [1:0] idx);
    lcd_op_t op;
    case (idx)
      2'd0:    op = cmd_op(FUNC_SET_8BIT);
      2'd1:    op = cmd_op(DISP_ON);
      2'd2:    op = cmd_op(CLEAR);
      default: op = cmd_op(ENTRY_INC);
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lcd_char_sequencer_if.sv
// rtl/lcd_char_sequencer_if.sv - byte handshake between the keyboard decoder and the sequencer
// Purpose: groups the valid/ready byte channel.
// Ports:   in_data (8) byte, in_valid byte valid, in_ready sink can accept.
//          master = byte source (decoder), slave = sequencer.
interface lcd_char_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/lcd_tick_gen.sv
// rtl/lcd_tick_gen.sv - free-running tick strobe used to pace LCD bus phases
// Purpose: counts 0..TICK_DIV-1 and emits a one-clk tick on the wrap cycle.
// Ports:   clk, reset_n (async active-low), tick (one-clk strobe).
module lcd_tick_gen #(
  parameter int TICK_DIV = 4096
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/lcd_char_sequencer.sv
// rtl/lcd_char_sequencer.sv - HD44780 16x2 init, byte-to-op expansion and E-strobe pacing
// Purpose: runs the power-on init, then turns accepted bytes into 0-3 LCD
//          write ops (char, newline, backspace, wrap) and tracks the cursor.
// Ports:   clk, reset_n (async active-low); in_if (slave) byte handshake;
//          lcd_data/lcd_rs/lcd_rw/lcd_e LCD pins; busy = !in_ready;
//          cursor_row/cursor_col current cursor.
module lcd_char_sequencer
  import lcd_pkg::*;
#(
  parameter int TICK_DIV      = 4096,
  parameter int POWERUP_TICKS = 256,
  parameter int CLEAR_TICKS   = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lcd_char_sequencer_if.slave  in_if,
  output logic [7:0]           lcd_data,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic                 busy,
  output logic                 cursor_row,
  output logic [3:0]           cursor_col
);

  localparam int            PW      = (POWERUP_TICKS > 1) ? $clog2(POWERUP_TICKS) : 1;
  localparam logic [PW-1:0] PU_LAST = PW'(POWERUP_TICKS - 1);
  localparam int            XW      = (CLEAR_TICKS > 1) ? $clog2(CLEAR_TICKS) : 1;
  localparam logic [XW-1:0] XW_LAST = XW'(CLEAR_TICKS - 1);

  logic tick;

  lcd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  lcd_state_e    state_q, state_d;
  lcd_phase_e    phase_q, phase_d;
  lcd_op_t       op_list_q [3];
  lcd_op_t       op_list_d [3];
  logic [1:0]    op_len_q, op_len_d;
  logic [1:0]    op_idx_q, op_idx_d;
  logic [1:0]    init_idx_q, init_idx_d;
  logic [PW-1:0] pu_cnt_q, pu_cnt_d;
  logic [XW-1:0] clr_cnt_q, clr_cnt_d;
  logic [7:0]    lcd_data_q, lcd_data_d;
  logic          lcd_rs_q, lcd_rs_d;
  logic          lcd_e_q, lcd_e_d;
  logic          in_ready_q, in_ready_d;
  logic          row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic          nxt_row_q, nxt_row_d;
  logic [3:0]    nxt_col_q, nxt_col_d;

  // Decode of the byte currently on in_data into an op list and target cursor.
  lcd_op_t       dec_ops [3];
  logic [1:0]    dec_len;
  logic          dec_row;
  logic [3:0]    dec_col;
  logic          bs_row;
  logic [3:0]    bs_col;
  logic [7:0]    bs_addr;

  always_comb begin
    dec_ops[0] = cmd_op(8'h00);
    dec_ops[1] = cmd_op(8'h00);
    dec_ops[2] = cmd_op(8'h00);
    dec_len    = 2'd0;
    dec_row    = row_q;
    dec_col    = col_q;
    // Column 0 of line 1 backs up to the end of line 0; 4-bit col wraps to 15.
    bs_row     = (col_q == 4'd0) ? 1'b0 : row_q;
    bs_col     = col_q - 4'd1;
    bs_addr    = ddram_addr(bs_row, bs_col);

    if (in_if.in_data >= PRINT_FIRST && in_if.in_data <= PRINT_LAST) begin
      dec_ops[0] = data_op(in_if.in_data);
      if (col_q == LAST_COL) begin
        dec_len = 2'd2;
        dec_col = 4'd0;
        if (!row_q) begin
          dec_ops[1] = cmd_op(DDRAM_L1);
          dec_row    = 1'b1;
        end else begin
          dec_ops[1] = cmd_op(CLEAR);
          dec_row    = 1'b0;
        end
      end else begin
        dec_len = 2'd1;
        dec_col = col_q + 4'd1;
      end
    end else if (in_if.in_data == LF) begin
      dec_len = 2'd1;
      dec_col = 4'd0;
      if (!row_q) begin
        dec_ops[0] = cmd_op(DDRAM_L1);
        dec_row    = 1'b1;
      end else begin
        dec_ops[0] = cmd_op(CLEAR);
        dec_row    = 1'b0;
      end
    end else if (in_if.in_data == BS) begin
      if (row_q || col_q != 4'd0) begin
        // Move back, blank the cell (which advances the cursor), move back again.
        dec_len    = 2'd3;
        dec_ops[0] = cmd_op(bs_addr);
        dec_ops[1] = data_op(SPACE);
        dec_ops[2] = cmd_op(bs_addr);
        dec_row    = bs_row;
        dec_col    = bs_col;
      end
    end
  end

  lcd_op_t    cur_op;
  lcd_op_t    load_val;
  logic       load_op;
  logic       op_done;
  logic [1:0] op_idx_nxt;

  assign cur_op     = (state_q == ST_INIT) ? init_op(init_idx_q) : op_list_q[op_idx_q];
  assign op_idx_nxt = (op_idx_q == 2'd2) ? 2'd2 : op_idx_q + 2'd1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    op_list_d  = op_list_q;
    op_len_d   = op_len_q;
    op_idx_d   = op_idx_q;
    init_idx_d = init_idx_q;
    pu_cnt_d   = pu_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    lcd_e_d    = lcd_e_q;
    in_ready_d = in_ready_q;
    row_d      = row_q;
    col_d      = col_q;
    nxt_row_d  = nxt_row_q;
    nxt_col_d  = nxt_col_q;
    load_op    = 1'b0;
    load_val   = cur_op;
    op_done    = 1'b0;

    case (state_q)
      ST_POWERUP: begin
        if (tick) begin
          if (pu_cnt_q == PU_LAST) begin
            state_d    = ST_INIT;
            init_idx_d = 2'd0;
            load_op    = 1'b1;
            load_val   = init_op(2'd0);
          end else begin
            pu_cnt_d = pu_cnt_q + PW'(1);
          end
        end
      end
      ST_IDLE: begin
        if (in_if.in_valid && in_ready_q) begin
          state_d    = ST_EXEC;
          phase_d    = PH_START;
          in_ready_d = 1'b0;
          op_list_d  = dec_ops;
          op_len_d   = dec_len;
          op_idx_d   = 2'd0;
          nxt_row_d  = dec_row;
          nxt_col_d  = dec_col;
        end
      end
      ST_EXEC: begin
        // Empty list: release the handshake on the very next edge, no tick wait.
        if (op_len_q == 2'd0) begin
          state_d    = ST_IDLE;
          in_ready_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (tick && (state_q == ST_INIT || (state_q == ST_EXEC && op_len_q != 2'd0))) begin
      case (phase_q)
        PH_START: begin
          load_op  = 1'b1;
          load_val = cur_op;
        end
        PH_SETUP: begin
          lcd_e_d = 1'b1;
          phase_d = PH_E_HI;
        end
        PH_E_HI: begin
          lcd_e_d = 1'b0;
          phase_d = PH_E_LO;
        end
        PH_E_LO: begin
          if (cur_op.long_wait) begin
            phase_d   = PH_CLR;
            clr_cnt_d = '0;
          end else begin
            op_done = 1'b1;
          end
        end
        PH_CLR: begin
          if (clr_cnt_q == XW_LAST) op_done = 1'b1;
          else                      clr_cnt_d = clr_cnt_q + XW'(1);
        end
        default: phase_d = PH_START;
      endcase
    end

    // Chain straight into the next op's SETUP on the tick that ends this one.
    if (op_done) begin
      if (state_q == ST_INIT) begin
        if (init_idx_q == 2'd3) begin
          state_d    = ST_IDLE;
          phase_d    = PH_START;
          in_ready_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + 2'd1;
          load_op    = 1'b1;
          load_val   = init_op(init_idx_q + 2'd1);
        end
      end else begin
        if (op_idx_q == op_len_q - 2'd1) begin
          state_d    = ST_IDLE;
          phase_d    = PH_START;
          in_ready_d = 1'b1;
          row_d      = nxt_row_q;
          col_d      = nxt_col_q;
        end else begin
          op_idx_d = op_idx_nxt;
          load_op  = 1'b1;
          load_val = op_list_q[op_idx_nxt];
        end
      end
    end

    if (load_op) begin
      lcd_rs_d   = load_val.rs;
      lcd_data_d = load_val.data;
      lcd_e_d    = 1'b0;
      phase_d    = PH_SETUP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_POWERUP;
      phase_q    <= PH_START;
      for (int i = 0; i < 3; i++) op_list_q[i] <= '0;
      op_len_q   <= 2'd0;
      op_idx_q   <= 2'd0;
      init_idx_q <= 2'd0;
      pu_cnt_q   <= '0;
      clr_cnt_q  <= '0;
      lcd_data_q <= 8'h00;
      lcd_rs_q   <= 1'b0;
      lcd_e_q    <= 1'b0;
      in_ready_q <= 1'b0;
      row_q      <= 1'b0;
      col_q      <= 4'd0;
      nxt_row_q  <= 1'b0;
      nxt_col_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      for (int i = 0; i < 3; i++) op_list_q[i] <= op_list_d[i];
      op_len_q   <= op_len_d;
      op_idx_q   <= op_idx_d;
      init_idx_q <= init_idx_d;
      pu_cnt_q   <= pu_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_e_q    <= lcd_e_d;
      in_ready_q <= in_ready_d;
      row_q      <= row_d;
      col_q      <= col_d;
      nxt_row_q  <= nxt_row_d;
      nxt_col_q  <= nxt_col_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign busy           = ~in_ready_q;
  assign lcd_data       = lcd_data_q;
  assign lcd_rs         = lcd_rs_q;
  assign lcd_rw         = 1'b0;
  assign lcd_e          = lcd_e_q;
  assign cursor_row     = row_q;
  assign cursor_col     = col_q;

endmodule

// File: tb/tb_lcd_char_sequencer.sv
// tb/tb_lcd_char_sequencer.sv - randomized self-checking bench for lcd_char_sequencer
module tb_lcd_char_sequencer;
  import lcd_pkg::*;

  localparam int TD = 4;
  localparam int PT = 8;
  localparam int CT = 3;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } op_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         width;
    int         gap;
    int         rise_cyc;
  } strobe_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, cursor_row;
  logic [3:0] cursor_col;

  lcd_char_sequencer_if in_if ();

  lcd_char_sequencer #(
    .TICK_DIV      (TD),
    .POWERUP_TICKS (PT),
    .CLEAR_TICKS   (CT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_if      (in_if),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .busy       (busy),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  op_t     eq[$];
  strobe_t sq[$];
  int      m_row = 0;
  int      m_col = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: records every E strobe and watches global invariants.
  logic       e_prev = 1'b0, rdy_prev = 1'b0, strobe_in_busy = 1'b0;
  logic       rise_rs;
  logic [7:0] rise_data;
  int         rise_cyc = 0, last_fall_cyc = 0;
  int         viol_e_rdy = 0, viol_busy = 0, viol_rdy_gap = 0, viol_hold = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (lcd_e && !e_prev) begin
        rise_cyc       = cyc;
        rise_rs        = lcd_rs;
        rise_data      = lcd_data;
        strobe_in_busy = 1'b1;
      end
      if (!lcd_e && e_prev) begin
        if (lcd_data !== rise_data || lcd_rs !== rise_rs) viol_hold++;
        sq.push_back('{rise_rs, rise_data, cyc - rise_cyc, rise_cyc - last_fall_cyc, rise_cyc});
        last_fall_cyc = cyc;
      end
      if (lcd_e && in_if.in_ready) viol_e_rdy++;
      if (in_if.in_ready && !rdy_prev) begin
        if (strobe_in_busy && (cyc - last_fall_cyc) < TD) viol_rdy_gap++;
        strobe_in_busy = 1'b0;
      end
    end else begin
      strobe_in_busy = 1'b0;
    end
    if (busy !== ~in_if.in_ready) viol_busy++;
    e_prev   = lcd_e;
    rdy_prev = in_if.in_ready;
  end

  // Reference model: cursor as a linear position 0..31 over both lines.
  task automatic model_byte(input logic [7:0] b);
    int pos;
    pos = m_row * 16 + m_col;
    eq.delete();
    if (b >= 8'h20 && b <= 8'h7E) begin
      eq.push_back('{1'b1, b});
      pos = pos + 1;
      if (pos == 16) eq.push_back('{1'b0, 8'hC0});
      else if (pos == 32) begin
        eq.push_back('{1'b0, 8'h01});
        pos = 0;
      end
    end else if (b == 8'h0A) begin
      if (pos < 16) begin
        eq.push_back('{1'b0, 8'hC0});
        pos = 16;
      end else begin
        eq.push_back('{1'b0, 8'h01});
        pos = 0;
      end
    end else if (b == 8'h08) begin
      if (pos > 0) begin
        pos = pos - 1;
        eq.push_back('{1'b0, 8'(8'h80 + (pos / 16) * 8'h40 + (pos % 16))});
        eq.push_back('{1'b1, 8'h20});
        eq.push_back('{1'b0, 8'(8'h80 + (pos / 16) * 8'h40 + (pos % 16))});
      end
    end
    m_row = pos / 16;
    m_col = pos % 16;
  endtask

  task automatic check_strobes(input string tag, input int t0, input int lo, input int hi);
    int n;
    int exp_gap;
    check_eq({tag, "_count"}, sq.size(), eq.size());
    n = (sq.size() < eq.size()) ? sq.size() : eq.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_rs%0d", tag, i), sq[i].rs, eq[i].rs);
      check_eq($sformatf("%s_data%0d", tag, i), sq[i].data, eq[i].data);
      check_eq($sformatf("%s_ehigh%0d", tag, i), sq[i].width, TD);
      if (i > 0) begin
        exp_gap = (!eq[i-1].rs && eq[i-1].data == 8'h01) ? (2 + CT) * TD : 2 * TD;
        check_eq($sformatf("%s_gap%0d", tag, i), sq[i].gap, exp_gap);
      end
    end
    if (n > 0)
      check_eq({tag, "_latency_in_window"},
               (sq[0].rise_cyc - t0 >= lo) && (sq[0].rise_cyc - t0 <= hi), 1'b1);
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_row"}, cursor_row, m_row);
    check_eq({tag, "_col"}, cursor_col, m_col);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hold_valid);
    int c0;
    int nneg;
    bit got;
    string tag;
    tag = $sformatf("byte%02h", b);
    model_byte(b);
    sq.delete();
    @(negedge clk);
    check_eq({tag, "_ready_idle"}, in_if.in_ready, 1'b1);
    in_if.in_data  = b;
    in_if.in_valid = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    check_eq({tag, "_ready_drop"}, in_if.in_ready, 1'b0);
    if (!hold_valid) in_if.in_valid = 1'b0;
    nneg = 0;
    got  = 1'b0;
    while (!got && nneg < 1000) begin
      @(negedge clk);
      nneg++;
      if (in_if.in_ready) got = 1'b1;
      else if (hold_valid) in_if.in_data = 8'($urandom);
    end
    in_if.in_valid = 1'b0;
    check_eq({tag, "_ready_return"}, got, 1'b1);
    if (eq.size() == 0) check_eq({tag, "_noop_ready_clks"}, nneg, 2);
    check_strobes(tag, c0 + 1, TD + 1, 2 * TD);
    check_cursor(tag);
  endtask

  task automatic release_and_check_init(input string tag);
    int rel;
    int nneg;
    bit got;
    eq.delete();
    eq.push_back('{1'b0, 8'h38});
    eq.push_back('{1'b0, 8'h0C});
    eq.push_back('{1'b0, 8'h01});
    eq.push_back('{1'b0, 8'h06});
    sq.delete();
    @(negedge clk);
    reset_n = 1'b1;
    rel = cyc;
    nneg = 0;
    got  = 1'b0;
    while (!got && nneg < 2000) begin
      @(negedge clk);
      nneg++;
      if (in_if.in_ready) got = 1'b1;
    end
    check_eq({tag, "_ready_after_init"}, got, 1'b1);
    check_strobes(tag, rel, PT * TD, (PT + 2) * TD);
    m_row = 0;
    m_col = 0;
    check_cursor(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    int         k;
    int         n;
    bit         got;

    in_if.in_data  = 8'h00;
    in_if.in_valid = 1'b0;
    repeat (4) @(negedge clk);

    check_eq("rst_lcd_e", lcd_e, 1'b0);
    check_eq("rst_lcd_rs", lcd_rs, 1'b0);
    check_eq("rst_lcd_rw", lcd_rw, 1'b0);
    check_eq("rst_lcd_data", lcd_data, 8'h00);
    check_eq("rst_in_ready", in_if.in_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_row", cursor_row, 1'b0);
    check_eq("rst_col", cursor_col, 4'd0);

    release_and_check_init("init");

    send_byte(8'h41, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0A, 1'b0);
    for (int i = 0; i < 32; i++) send_byte(8'h61, (i % 5) == 2);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h08, 1'b1);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'h1B, 1'b1);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 5)      rb = 8'($urandom_range(32, 126));
      else if (k == 6) rb = 8'h0A;
      else if (k <= 8) rb = 8'h08;
      else begin
        rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 31));
        if (rb == 8'h08 || rb == 8'h0A) rb = 8'h7F;
      end
      send_byte(rb, $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    in_if.in_data  = 8'h5A;
    in_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_if.in_valid = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (lcd_e) got = 1'b1;
    end
    check_eq("mid_op_e_seen", got, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_op_rst_e_drop", lcd_e, 1'b0);
    check_eq("mid_op_rst_ready", in_if.in_ready, 1'b0);
    check_eq("mid_op_rst_busy", busy, 1'b1);
    check_eq("mid_op_rst_row", cursor_row, 1'b0);
    check_eq("mid_op_rst_col", cursor_col, 4'd0);
    repeat (5) @(posedge clk);
    release_and_check_init("reinit");
    send_byte(8'h42, 1'b0);

    check_eq("inv_e_while_ready", viol_e_rdy, 0);
    check_eq("inv_busy_not_ready", viol_busy, 0);
    check_eq("inv_e_low_before_ready", viol_rdy_gap, 0);
    check_eq("inv_data_held_in_e", viol_hold, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_char_sequencer.md
# lcd_char_sequencer

Sequences all bus traffic to the HD44780-compatible character LCD (16x2, 8-bit mode, write-only). It runs the power-on init sequence, then accepts keyboard-decoded bytes over a valid/ready handshake and expands each into LCD write operations: characters, newline, backspace and automatic line wrap. It tracks the cursor, and paces every E strobe from an internal tick rather than a divided clock. It sits between the PS/2 scancode decoder and the LCD pins.

## Interface
- TICK_DIV, 4096: clk cycles per tick (50 MHz gives 81.92 us per tick).
- POWERUP_TICKS, 256: ticks waited after reset before the first init write.
- CLEAR_TICKS, 24: extra ticks after a clear-display (0x01) write.
- clk  in  1  system clock; one clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII byte from the decoder.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a byte.
- lcd_data  out  8  LCD DB7..DB0.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied 0.
- lcd_e  out  1  enable strobe.
- busy  out  1  high whenever in_ready is low.
- cursor_row  out  1  current line, 0 or 1.
- cursor_col  out  4  current column, 0..15.

## Operation
- Tick generator: a free-running counter 0..TICK_DIV-1 with a wrap at TICK_DIV-1. The tick is a one-clk strobe on the wrap. All FSM phase changes happen only on a tick.
- Write op: three tick intervals.
  - SETUP: rs and data driven, e=0.
  - E_HI: e=1.
  - E_LO: e=0, data held.
  - Op 0x01 then adds CLEAR_TICKS intervals with e=0.
- States:
  - POWERUP waits POWERUP_TICKS, then goes to INIT.
  - INIT issues 0x38, 0x0C, 0x01, 0x06 in order, then goes to IDLE.
  - IDLE drives in_ready=1.
  - Accepting a byte moves to EXEC.
  - EXEC runs an op list of 1-3 ops, then returns to IDLE.
- Byte mapping, cursor (r,c):
  - 0x20..0x7E: data write of the byte, then c+1.
  - Character at c=15, r=0: append command 0xC0; cursor becomes (1,0).
  - Character at (1,15): append 0x01; cursor becomes (0,0).
  - 0x0A: r=0 issues 0xC0 with cursor (1,0); r=1 issues 0x01 with cursor (0,0).
  - 0x08 at c>0: cmd 0x80|(r<<6)|(c-1), data 0x20, then the same command again; c-1.
  - 0x08 at (1,0): the same three ops targeting (0,15); cursor (0,15).
  - 0x08 at (0,0): accepted, no bus activity.
  - Any other byte: accepted, no bus activity, cursor unchanged.
- Cursor outputs update when the final op of the list completes.

## Timing
- Reset values:
  - lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
  - in_ready=0, busy=1.
  - cursor_row=0, cursor_col=0.
  - State POWERUP; tick counter 0.
- Handshake:
  - A byte transfers on the rising edge where in_valid and in_ready are both 1.
  - in_ready is 0 from the next cycle until the op list finishes.
  - in_data is sampled only on that transfer.
  - A no-op byte returns in_ready=1 on the second cycle after the transfer.
- Latency: the first SETUP begins on the first tick after the transfer.
- lcd_e is high for exactly TICK_DIV clk cycles per op.
- A new op never starts SETUP before the previous op's E_LO (and any clear wait) has elapsed.
- When in_ready rises, lcd_e has been 0 for at least one tick.
- Reset asserted mid-op forces lcd_e=0 immediately. On release, the full POWERUP and INIT sequence reruns.
- in_valid held high while busy has no effect; there is no buffering.

## Structure
- Shared package lcd_pkg holds:
  - Command constants: FUNC_SET_8BIT=0x38, DISP_ON=0x0C, CLEAR=0x01, ENTRY_INC=0x06, DDRAM_L0=0x80, DDRAM_L1=0xC0.
  - ASCII constants BS=0x08, LF=0x0A.
  - The FSM state enum.
- One sub-module, lcd_tick_gen: parameterised by TICK_DIV; ports clk, reset_n and tick.
- The op list is a 3-entry register array {rs, data, long_wait} with a 2-bit length and a 2-bit index.

## Test plan
- Use TICK_DIV=4, POWERUP_TICKS=8, CLEAR_TICKS=3.
- Reset release: in_ready rises only after the E strobes carrying 0x38, 0x0C, 0x01 and 0x06, all with rs=0. The 0x01 op is followed by 3 extra tick intervals, and each E high lasts 4 clks.
- Send 0x41: one strobe with rs=1, data=0x41. Cursor becomes (0,1); in_ready is low for the full op.
- Send 16 bytes of 0x61: the 16th is followed by a 0xC0 command strobe, and the cursor becomes (1,0). Sixteen more produce a 0x01 strobe plus the clear wait, and the cursor becomes (0,0).
- Backspace, starting at (0,3): strobes 0x82 (rs=0), 0x20 (rs=1), 0x82 (rs=0); cursor (0,2). At (1,0): 0x8F, 0x20, 0x8F; cursor (0,15). At (0,0): no strobe, and in_ready returns within 2 clks.
- Send 0x0A at row 0: 0xC0 strobe, cursor (1,0). Send 0x0A again: 0x01 strobe, cursor (0,0). Send 0x1B: no strobe, cursor unchanged.
- Assert reset_n low while lcd_e=1: lcd_e drops in the same cycle, and the POWERUP/INIT sequence restarts after release.
